// File: rtl/add_defs.sv
// Shared definitions for the multi-word sequential adder: word size, FSM
// state encoding and operation mode codes.
package add_defs;

  localparam int TAILLE_MOT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/operation16.sv
// Combinational 16-bit slice adder: {r1, s} = e1 + e2 + r0.
module operation16
  import add_defs::*;
(
  input  logic [TAILLE_MOT-1:0] e1,
  input  logic [TAILLE_MOT-1:0] e2,
  input  logic                  r0,
  output logic [TAILLE_MOT-1:0] s,
  output logic                  r1
);

  assign {r1, s} = {1'b0, e1} + {1'b0, e2} + {{TAILLE_MOT{1'b0}}, r0};

endmodule

// File: rtl/add_multimot_seq.sv
// Sequential NB_MOTS x 16-bit adder/subtractor: one word per cycle through a
// single slice adder, LSW first, with valid/ready handshakes on both sides.
module add_multimot_seq
  import add_defs::*;
#(
  parameter int NB_MOTS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mode,
  input  logic [TAILLE_MOT*NB_MOTS-1:0] e1,
  input  logic [TAILLE_MOT*NB_MOTS-1:0] e2,
  input  logic                          r0,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TAILLE_MOT*NB_MOTS-1:0] s,
  output logic                          r1
);

  localparam int W     = TAILLE_MOT * NB_MOTS;
  localparam int CNT_W = $clog2(NB_MOTS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB_MOTS - 1);

  state_t           state_reg, state_next;
  logic [W-1:0]     a_reg, a_next;
  logic [W-1:0]     b_reg, b_next;
  logic [W-1:0]     s_reg, s_next;
  logic             carry_reg, carry_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_valid_reg, out_valid_next;

  logic [TAILLE_MOT-1:0] slice_s;
  logic                  slice_c;

  operation16 u_slice (
    .e1 (a_reg[TAILLE_MOT-1:0]),
    .e2 (b_reg[TAILLE_MOT-1:0]),
    .r0 (carry_reg),
    .s  (slice_s),
    .r1 (slice_c)
  );

  always_comb begin
    state_next     = state_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    s_next         = s_reg;
    carry_next     = carry_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next     = e1;
          b_next     = (mode == MODE_SUB) ? ~e2 : e2;
          carry_next = (mode == MODE_SUB) ? 1'b1 : r0;
          cnt_next   = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        // Result fills from the top so the LSW lands at bit 0 after NB_MOTS shifts.
        s_next     = {slice_s, s_reg[W-1:TAILLE_MOT]};
        carry_next = slice_c;
        a_next     = a_reg >> TAILLE_MOT;
        b_next     = b_reg >> TAILLE_MOT;
        if (cnt_reg == LAST) begin
          state_next     = DONE;
          out_valid_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      s_reg         <= '0;
      carry_reg     <= 1'b0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      s_reg         <= s_next;
      carry_reg     <= carry_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign s         = s_reg;
  // The carry register is frozen in DONE, so it doubles as the final carry-out.
  assign r1        = carry_reg;

endmodule

// File: tb/tb_add_multimot_seq.sv
// Self-checking bench for add_multimot_seq (NB_MOTS = 4): directed literal
// cases plus a randomized stream checked against a plain-arithmetic model.
module tb_add_multimot_seq;

  localparam int N = 4;
  localparam int W = 16 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         mode = 1'b0;
  logic [W-1:0] e1 = '0;
  logic [W-1:0] e2 = '0;
  logic         r0 = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         r1;

  add_multimot_seq #(.NB_MOTS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .e1        (e1),
    .e2        (e2),
    .r0        (r0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .r1        (r1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit stream_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok,
                     input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: unsigned wide arithmetic; subtract carry means "no borrow".
  function automatic logic [W:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic m);
    logic [W:0] res;
    if (m) begin
      res[W-1:0] = a - b;
      res[W]     = (a >= b);
    end else begin
      res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end
    return res;
  endfunction

  function automatic logic [W-1:0] rand64();
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: v = '1;
      1: v = '0;
      2: v = {48'h0, v[15:0]};
      3: v = {v[63:16], 16'hFFFF};
      default: ;
    endcase
    return v;
  endfunction

  // Monitor: samples on the falling edge, sees accepts one half-cycle before they happen.
  logic [W:0] exp_q[$];
  int         acc_q[$];
  bit         prev_held = 1'b0;
  bit         have_prev_acc = 1'b0;
  int         prev_acc = 0;

  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      prev_held = 1'b0;
      have_prev_acc = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_result", 1'b0, {r1, s}, '0);
        end else begin
          e = exp_q[0];
          chk("mon_s", s == e[W-1:0], {1'b0, s}, {1'b0, e[W-1:0]});
          chk("mon_r1", r1 == e[W], {{W{1'b0}}, r1}, {{W{1'b0}}, e[W]});
          chk("mon_in_ready_busy", in_ready == 1'b0, {{W{1'b0}}, in_ready}, '0);
          if (!prev_held)
            chk("mon_latency", (cyc - acc_q[0]) == N, (W+1)'(cyc - acc_q[0]), (W+1)'(N));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      prev_held = out_valid && !out_ready;
      if (in_valid && in_ready) begin
        exp_q.push_back(golden(e1, e2, r0, mode));
        acc_q.push_back(cyc + 1);
        if (stream_on && have_prev_acc)
          chk("mon_period", (cyc + 1 - prev_acc) == N + 2,
              (W+1)'(cyc + 1 - prev_acc), (W+1)'(N + 2));
        prev_acc = cyc + 1;
        have_prev_acc = 1'b1;
      end
    end
  end

  task automatic wait_valid(output int waited);
    waited = 0;
    while (!out_valid && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!out_valid) chk("wait_out_valid_timeout", 1'b0, '0, 1);
  endtask

  // Drives one operation from IDLE and checks it against literal expectations.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic m,
                        input logic [W-1:0] exp_s, input logic exp_r1,
                        output int waited);
    e1 = a; e2 = b; r0 = cin; mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(waited);
    chk({name, "_s"}, s == exp_s, {1'b0, s}, {1'b0, exp_s});
    chk({name, "_r1"}, r1 == exp_r1, {{W{1'b0}}, r1}, {{W{1'b0}}, exp_r1});
    $display("op %s: e1=%h e2=%h r0=%0d mode=%0d -> s=%h r1=%0d latency=%0d",
             name, a, b, cin, m, s, r1, waited);
    @(posedge clk); #1;
  endtask

  initial begin
    int waited;
    int accepts;
    int guard;
    logic [W-1:0] held_s;
    logic         held_r1;

    #1;
    chk("reset_s", s == '0, {1'b0, s}, '0);
    chk("reset_r1", r1 == 1'b0, {{W{1'b0}}, r1}, '0);
    chk("reset_out_valid", out_valid == 1'b0, {{W{1'b0}}, out_valid}, '0);
    chk("reset_in_ready", in_ready == 1'b1, {{W{1'b0}}, in_ready}, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. carry across a word boundary, exact latency
    run_op("t1_word_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0000_0000_0001_0000, 1'b0, waited);
    chk("t1_latency", waited == N, (W+1)'(waited), (W+1)'(N));
    // 2. full ripple
    run_op("t2_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, waited);
    // 3. subtract, r0 ignored
    run_op("t3_sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, waited);
    run_op("t3_sub_ok", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, waited);

    // 4. backpressure
    out_ready = 1'b0;
    e1 = 64'h1111_1111_1111_1111; e2 = 64'h2222_2222_2222_2222; r0 = 1'b0; mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(waited);
    chk("t4_s", s == 64'h3333_3333_3333_3333, {1'b0, s}, {1'b0, 64'h3333_3333_3333_3333});
    held_s = s; held_r1 = r1;
    for (int i = 0; i < 10; i++) begin
      e1 = rand64(); e2 = rand64(); mode = ~mode; r0 = ~r0; in_valid = i[0];
      @(posedge clk); #1;
      chk("t4_hold_s", s == held_s, {1'b0, s}, {1'b0, held_s});
      chk("t4_hold_r1", r1 == held_r1, {{W{1'b0}}, r1}, {{W{1'b0}}, held_r1});
      chk("t4_hold_valid", out_valid == 1'b1, {{W{1'b0}}, out_valid}, 1);
      chk("t4_in_ready", in_ready == 1'b0, {{W{1'b0}}, in_ready}, '0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_release_valid", out_valid == 1'b0, {{W{1'b0}}, out_valid}, '0);
    chk("t4_release_idle", in_ready == 1'b1, {{W{1'b0}}, in_ready}, 1);
    $display("op t4_backpressure: held s=%h r1=%0d for 10 cycles", held_s, held_r1);

    // 5. reset in the middle of a calculation
    e1 = 64'hAAAA_AAAA_AAAA_AAAA; e2 = 64'h5555_5555_5555_5555; r0 = 1'b1; mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_s", s == '0, {1'b0, s}, '0);
    chk("t5_rst_r1", r1 == 1'b0, {{W{1'b0}}, r1}, '0);
    chk("t5_rst_valid", out_valid == 1'b0, {{W{1'b0}}, out_valid}, '0);
    chk("t5_rst_in_ready", in_ready == 1'b1, {{W{1'b0}}, in_ready}, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("t5_after_reset", 64'h1234_5678_9ABC_DEF0, 64'h1, 1'b0, 1'b0,
           64'h1234_5678_9ABC_DEF1, 1'b0, waited);

    // 6. random streaming
    stream_on = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    accepts = 0;
    guard = 0;
    while (guard < 7000) begin
      if (in_ready) begin
        if (accepts == 1000) break;
        e1 = rand64(); e2 = rand64(); r0 = 1'($urandom); mode = 1'($urandom);
        accepts++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    chk("t6_accepts", accepts == 1000, (W+1)'(accepts), (W+1)'(1000));
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("t6_drained", exp_q.size() == 0, (W+1)'(exp_q.size()), '0);
    stream_on = 1'b0;
    $display("op t6_stream: %0d random operations issued", accepts);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
